// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Prefixed so the DATA state cannot collide with the DATA output port.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-stage bit synchronizer, resets to line-idle high
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with mid-bit sampling and valid/ready output
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV    = 234,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      CLK,
    input  logic                      RESET_n,
    input  logic                      RXD,
    output logic [UART_DATA_BITS-1:0] DATA,
    output logic                      VALID,
    input  logic                      READY,
    output logic                      FRAME_ERR,
    output logic                      OVERRUN,
    output logic                      BUSY
);

    localparam int TW = $clog2(BAUD_DIV);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] T_FULL   = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(BAUD_DIV / 2 - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(UART_DATA_BITS - 1);

    uart_rx_state_t            state, state_n;
    logic [TW-1:0]             timer, timer_val;
    logic [IW-1:0]             bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      rxd_s;
    logic                      tick;
    logic                      timer_ld;
    logic                      shift_en;
    logic                      idx_clr;
    logic                      idx_inc;
    logic                      byte_done;
    logic                      stop_bad;

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (CLK),
        .rst_n(RESET_n),
        .d    (RXD),
        .q    (rxd_s)
    );

    assign tick = (timer == '0);
    assign BUSY = (state != ST_IDLE);

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_ld  = 1'b0;
        timer_val = '0;
        shift_en  = 1'b0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_n   = ST_START;
                    timer_ld  = 1'b1;
                    timer_val = T_HALF;
                end
            end
            ST_START: begin
                if (tick) begin
                    timer_ld = 1'b1;
                    if (rxd_s) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n   = ST_DATA;
                        timer_val = T_FULL;
                        idx_clr   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_en  = 1'b1;
                    timer_ld  = 1'b1;
                    timer_val = T_FULL;
                    if (bit_idx == LAST_BIT) begin
                        state_n = ST_STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    timer_ld = 1'b1;
                    if (rxd_s) begin
                        byte_done = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_n  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold here until the line returns high so a long low cannot look like a start bit.
                if (rxd_s) begin
                    state_n  = ST_IDLE;
                    timer_ld = 1'b1;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                timer_ld = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (timer_ld) begin
                timer <= timer_val;
            end else if (!tick) begin
                timer <= timer - 1'b1;
            end
            if (idx_clr) begin
                bit_idx <= '0;
            end else if (idx_inc) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shift_reg <= {rxd_s, shift_reg[UART_DATA_BITS-1:1]};
            end
        end
    end

    // A new byte always wins over a same-cycle consume, so VALID stays high.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            DATA      <= '0;
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            FRAME_ERR <= stop_bad;
            OVERRUN   <= byte_done && VALID && !READY;
            if (byte_done) begin
                DATA  <= shift_reg;
                VALID <= 1'b1;
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a transaction-level model
module tb_uart_rx;

    localparam int BAUD = 16;
    localparam int SYNC = 2;
    // Stop-bit sample edge after driving the start edge just after posedge n.
    localparam int LAT  = SYNC + BAUD / 2 + 9 * BAUD + 1;

    typedef struct {
        int         cyc;
        logic [7:0] b;
        logic       ok;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RESET_n;
    logic       RXD;
    logic [7:0] DATA;
    logic       VALID;
    logic       READY;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int         cyc = 0;
    logic       rdy_edge = 1'b0;
    int         checks = 0;
    int         errors = 0;
    ev_t        ev_q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic       prev_valid = 1'b0;
    int         rise_cyc = -1;
    int         ovr_cnt = 0;
    int         ferr_cnt = 0;

    uart_rx #(
        .BAUD_DIV   (BAUD),
        .SYNC_STAGES(SYNC)
    ) dut (
        .CLK      (CLK),
        .RESET_n  (RESET_n),
        .RXD      (RXD),
        .DATA     (DATA),
        .VALID    (VALID),
        .READY    (READY),
        .FRAME_ERR(FRAME_ERR),
        .OVERRUN  (OVERRUN),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rdy_edge <= READY;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: each frame completes at a known edge; the output register follows the handshake rules.
    always @(negedge CLK) begin
        if (RESET_n === 1'b1) begin
            logic exp_f, exp_o, hit;
            ev_t  e;
            exp_f = 1'b0;
            exp_o = 1'b0;
            hit   = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e   = ev_q.pop_front();
                hit = 1'b1;
            end
            if (hit && e.ok) begin
                exp_o   = m_valid && !rdy_edge;
                m_data  = e.b;
                m_valid = 1'b1;
            end else begin
                exp_f = hit;
                if (m_valid && rdy_edge) m_valid = 1'b0;
            end
            chk("valid", VALID, m_valid);
            chk("data", DATA, m_data);
            chk("frame_err", FRAME_ERR, exp_f);
            chk("overrun", OVERRUN, exp_o);
            if (VALID && !prev_valid) rise_cyc = cyc;
            prev_valid = VALID;
            if (OVERRUN) ovr_cnt++;
            if (FRAME_ERR) ferr_cnt++;
        end
    end

    task automatic idle(input int k);
        repeat (k) @(negedge CLK);
    endtask

    // Called at a negedge; returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int period, output int n);
        ev_t e;
        RXD   = 1'b0;
        n     = cyc;
        e.cyc = n + LAT;
        e.b   = b;
        e.ok  = stop;
        ev_q.push_back(e);
        repeat (period) @(negedge CLK);
        for (int k = 0; k < 8; k++) begin
            RXD = b[k];
            repeat (period) @(negedge CLK);
        end
        RXD = stop;
        repeat (period) @(negedge CLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n, n2, o0, f0;
        logic [7:0] pat;
        RXD     = 1'b1;
        READY   = 1'b0;
        RESET_n = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_data", DATA, 8'h00);
        chk("rst_valid", VALID, 1'b0);
        chk("rst_ferr", FRAME_ERR, 1'b0);
        chk("rst_ovr", OVERRUN, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        #3 RESET_n = 1'b1;
        @(negedge CLK);
        idle(4);

        // Single byte, consumer always ready
        READY = 1'b1;
        send_frame(8'hA5, 1'b1, BAUD, n);
        idle(10);
        chk("t1_latency", rise_cyc, n + 155);
        chk("t1_data", DATA, 8'hA5);
        chk("t1_valid_pulse", VALID, 1'b0);
        chk("t1_flags", ovr_cnt + ferr_cnt, 0);

        // Two back-to-back bytes without consuming
        READY = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h3C, 1'b1, BAUD, n);
        send_frame(8'hFF, 1'b1, BAUD, n);
        idle(10);
        chk("t2_overrun_once", ovr_cnt - o0, 1);
        chk("t2_data", DATA, 8'hFF);
        chk("t2_valid_held", VALID, 1'b1);
        READY = 1'b1;
        idle(2);
        chk("t2_consumed", VALID, 1'b0);
        READY = 1'b0;

        // Short low glitch on idle line
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        RXD = 1'b0;
        idle(6);
        RXD = 1'b1;
        chk("t3_busy_during", BUSY, 1'b1);
        idle(15);
        chk("t3_busy_after", BUSY, 1'b0);
        chk("t3_valid", VALID, 1'b0);
        chk("t3_flags", (ovr_cnt - o0) + (ferr_cnt - f0), 0);

        // Framing error followed by a long break, then a good byte
        f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, BAUD, n);
        idle(40 * BAUD);
        chk("t4_ferr_once", ferr_cnt - f0, 1);
        chk("t4_busy_break", BUSY, 1'b1);
        chk("t4_no_byte", VALID, 1'b0);
        RXD = 1'b1;
        idle(32);
        send_frame(8'h12, 1'b1, BAUD, n);
        idle(10);
        chk("t4_data", DATA, 8'h12);
        chk("t4_valid", VALID, 1'b1);
        READY = 1'b1;
        idle(2);
        READY = 1'b0;

        // Reset during bit 4 of 0x81
        pat = 8'h81;
        RXD = 1'b0;
        idle(BAUD);
        for (int k = 0; k < 4; k++) begin
            RXD = pat[k];
            idle(BAUD);
        end
        RXD = pat[4];
        idle(BAUD / 2);
        #2 RESET_n = 1'b0;
        ev_q.delete();
        m_valid    = 1'b0;
        m_data     = 8'h00;
        prev_valid = 1'b0;
        #1;
        chk("t5_data", DATA, 8'h00);
        chk("t5_valid", VALID, 1'b0);
        chk("t5_busy", BUSY, 1'b0);
        chk("t5_flags", {FRAME_ERR, OVERRUN}, 2'b00);
        RXD = 1'b1;
        idle(2);
        #3 RESET_n = 1'b1;
        @(negedge CLK);
        idle(4);
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        READY = 1'b1;
        send_frame(8'h7E, 1'b1, BAUD, n);
        idle(10);
        chk("t5_latency", rise_cyc, n + 155);
        chk("t5_data_after", DATA, 8'h7E);
        chk("t5_no_flags", (ovr_cnt - o0) + (ferr_cnt - f0), 0);

        // Second byte lands in the same cycle the first is accepted
        READY = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h5A, 1'b1, BAUD, n);
        fork
            send_frame(8'h6C, 1'b1, BAUD, n2);
            begin
                idle(154);
                READY = 1'b1;
                idle(1);
                READY = 1'b0;
            end
        join
        idle(5);
        chk("t6_valid", VALID, 1'b1);
        chk("t6_data", DATA, 8'h6C);
        chk("t6_no_overrun", ovr_cnt - o0, 0);
        READY = 1'b1;
        idle(2);

        // Baud mismatch in both directions
        send_frame(8'hC3, 1'b1, 15, n);
        idle(20);
        chk("slow15_latency", rise_cyc, n + 155);
        chk("slow15_data", DATA, 8'hC3);
        send_frame(8'hC3, 1'b1, 17, n);
        idle(20);
        chk("fast17_latency", rise_cyc, n + 155);
        chk("fast17_data", DATA, 8'hC3);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
